// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: op codes and FSM state encoding shared by the SR latch driver.
package sr_drv_pkg;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_CHECK} state_t;
endpackage

// File: rtl/sr_drv_phase_timer.sv
// sr_drv_phase_timer: loadable down-counter that holds at zero and flags it.
module sr_drv_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? val : (cnt != '0 ? cnt - CNT_W'(1) : cnt);
  assign zero = cnt == '0;
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences s/r setup, en pulse and hold for a gated SR latch.
// Define SR_DRV_READBACK_EN to add a CHECK phase that verifies q/q_bar readback.
module sr_latch_driver import sr_drv_pkg::*; #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  output logic       s,
  output logic       r,
  output logic       en,
  input  logic       q_fb,
  input  logic       q_bar_fb,
  output logic       done,
  output logic       err,
  output logic       busy
);
  localparam int S_EFF = SETUP_CYC < 1 ? 1 : SETUP_CYC;
  localparam int P_EFF = PULSE_CYC < 1 ? 1 : PULSE_CYC;
  localparam int H_EFF = HOLD_CYC < 1 ? 1 : HOLD_CYC;
  localparam logic [CNT_W-1:0] S_LD = CNT_W'(S_EFF - 1);
  localparam logic [CNT_W-1:0] P_LD = CNT_W'(P_EFF - 1);
  localparam logic [CNT_W-1:0] H_LD = CNT_W'(H_EFF - 1);
  state_t state, nxt;
  logic [1:0] op, op_n;
  logic ld, zero, done_n, err_n, drive_n;
  logic [CNT_W-1:0] ld_val;
  sr_drv_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(ld),
    .val(ld_val),
    .zero(zero)
  );
`ifndef SR_DRV_READBACK_EN
  logic unused_fb;
  assign unused_fb = q_fb ^ q_bar_fb;
`endif
  always_comb begin
    nxt = state;
    op_n = op;
    ld = 1'b0;
    ld_val = S_LD;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      ST_IDLE:
        if (req_valid && req_ready) begin
          op_n = req_op;
          if (req_op == OP_SET || req_op == OP_CLEAR) begin
            nxt = ST_SETUP;
            ld = 1'b1;
          end
          done_n = req_op == OP_NOP;
          err_n = req_op == OP_ILLEGAL;
        end
      ST_SETUP:
        if (zero) begin
          nxt = ST_PULSE;
          ld = 1'b1;
          ld_val = P_LD;
        end
      ST_PULSE:
        if (zero) begin
          nxt = ST_HOLD;
          ld = 1'b1;
          ld_val = H_LD;
        end
      ST_HOLD:
        if (zero) begin
`ifdef SR_DRV_READBACK_EN
          nxt = ST_CHECK;
`else
          nxt = ST_IDLE;
          done_n = 1'b1;
`endif
        end
`ifdef SR_DRV_READBACK_EN
      ST_CHECK: begin
        nxt = ST_IDLE;
        done_n = q_fb == (op == OP_SET) && q_bar_fb == (op != OP_SET);
        err_n = !done_n;
      end
`endif
      default: nxt = ST_IDLE;
    endcase
  end
  assign drive_n = nxt inside {ST_SETUP, ST_PULSE, ST_HOLD};
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      op <= OP_NOP;
      s <= 1'b0;
      r <= 1'b0;
      en <= 1'b0;
      req_ready <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      op <= op_n;
      s <= drive_n && op_n == OP_SET;
      r <= drive_n && op_n == OP_CLEAR;
      en <= nxt == ST_PULSE;
      req_ready <= nxt == ST_IDLE;
      done <= done_n;
      err <= err_n;
    end
  assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: table vectors, corner sequences and random traffic vs a transaction-level model.
module tb_sr_latch_driver;
  import sr_drv_pkg::*;
  localparam int S = 1, P = 2, H = 1;
`ifdef SR_DRV_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  typedef struct {
    logic v;
    logic [1:0] op;
    logic [6:0] e;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req_valid = 1'b0, q_fb = 1'b0, q_bar_fb = 1'b1;
  logic [1:0] req_op = OP_NOP;
  logic req_ready, s, r, en, done, err, busy;
  logic v2 = 1'b0;
  logic [1:0] op2 = OP_NOP;
  logic ready2, s2, r2, en2, done2, err2, busy2;
  int nvec = 0, nbad = 0;
  logic [7:0] cur;
  logic [7:0] plan[$];
  logic q_exp;
  vec_t tbl[$];
  always #5 clk = ~clk;
  sr_latch_driver dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .s(s), .r(r), .en(en), .q_fb(q_fb), .q_bar_fb(q_bar_fb), .done(done), .err(err), .busy(busy)
  );
  sr_latch_driver #(.SETUP_CYC(0), .PULSE_CYC(3), .HOLD_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(ready2), .req_op(op2),
    .s(s2), .r(r2), .en(en2), .q_fb(1'b0), .q_bar_fb(1'b1), .done(done2), .err(err2), .busy(busy2)
  );
  function automatic logic [6:0] act();
    return {s, r, en, req_ready, done, err, busy};
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
    end
  endtask
  task automatic add(input logic v, input logic [1:0] op, input logic [6:0] e);
    tbl.push_back('{v: v, op: op, e: e});
  endtask
  // Model: a command expands into a list of per-cycle output words {chk,s,r,en,ready,done,err,busy}.
  task automatic cyc(input logic v, input logic [1:0] o, input logic qf, input logic qbf);
    logic [7:0] nxt;
    logic [1:0] sr;
    logic ok;
    req_valid = v;
    req_op = o;
    q_fb = qf;
    q_bar_fb = qbf;
    if (cur[7]) begin
      ok = qf == q_exp && qbf == !q_exp;
      nxt = {4'b0000, 1'b1, ok, !ok, 1'b0};
    end else if (v && cur[3]) begin
      if (o == OP_NOP) nxt = 8'b0_0001100;
      else if (o == OP_ILLEGAL) nxt = 8'b0_0001010;
      else begin
        sr = o == OP_SET ? 2'b10 : 2'b01;
        q_exp = o == OP_SET;
        for (int i = 0; i < S; i++) plan.push_back({1'b0, sr, 1'b0, 4'b0001});
        for (int i = 0; i < P; i++) plan.push_back({1'b0, sr, 1'b1, 4'b0001});
        for (int i = 0; i < H; i++) plan.push_back({1'b0, sr, 1'b0, 4'b0001});
        plan.push_back(RB == 1 ? 8'b1_0000001 : 8'b0_0001100);
        nxt = plan.pop_front();
      end
    end else if (plan.size() != 0) nxt = plan.pop_front();
    else nxt = 8'b0_0001000;
    @(negedge clk);
    cur = nxt;
    chk("model", act(), cur[6:0]);
  endtask
  initial begin
    int en_cnt, k_done;
    logic [1:0] de;
    // SET with matching readback
    add(1, OP_SET, 7'b1000001); add(0, OP_NOP, 7'b1010001); add(0, OP_NOP, 7'b1010001);
    add(0, OP_NOP, 7'b1000001);
`ifdef SR_DRV_READBACK_EN
    add(0, OP_NOP, 7'b0000001);
`endif
    add(0, OP_NOP, 7'b0001100);
    // CLEAR while q reads back 1
    add(1, OP_CLEAR, 7'b0100001); add(0, OP_NOP, 7'b0110001); add(0, OP_NOP, 7'b0110001);
    add(0, OP_NOP, 7'b0100001);
`ifdef SR_DRV_READBACK_EN
    add(0, OP_NOP, 7'b0000001); add(0, OP_NOP, 7'b0001010);
`else
    add(0, OP_NOP, 7'b0001100);
`endif
    // ILLEGAL, then SET accepted in the err cycle
    add(1, OP_ILLEGAL, 7'b0001010); add(1, OP_SET, 7'b1000001); add(0, OP_NOP, 7'b1010001);
    add(0, OP_NOP, 7'b1010001); add(0, OP_NOP, 7'b1000001);
`ifdef SR_DRV_READBACK_EN
    add(0, OP_NOP, 7'b0000001);
`endif
    add(0, OP_NOP, 7'b0001100);
    // NOP, then SET held valid throughout
    add(1, OP_NOP, 7'b0001100); add(1, OP_SET, 7'b1000001); add(1, OP_SET, 7'b1010001);
    add(1, OP_SET, 7'b1010001); add(1, OP_SET, 7'b1000001);
`ifdef SR_DRV_READBACK_EN
    add(1, OP_SET, 7'b0000001);
`endif
    add(0, OP_NOP, 7'b0001100);
    #1 rst_n = 1'b0;
    #2 chk("reset state", act(), 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 8'b0;
    cyc(0, OP_NOP, 1, 0);
    chk("ready after reset", act(), 7'b0001000);
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].op, 1'b1, 1'b0);
      chk("table", act(), tbl[i].e);
    end
    // Reset while in PULSE
    cyc(1, OP_SET, 1, 0);
    cyc(0, OP_NOP, 1, 0);
    chk("in pulse", act(), 7'b1010001);
    #2 rst_n = 1'b0;
    #1 chk("async abort", act(), 7'b0);
    cur = 8'b0;
    plan.delete();
    @(negedge clk);
    @(negedge clk);
    chk("held in reset", act(), 7'b0);
    rst_n = 1'b1;
    cyc(0, OP_NOP, 1, 0);
    chk("ready after abort", act(), 7'b0001000);
    // Zero setup, 3-cycle pulse instance
    v2 = 1'b1;
    op2 = OP_SET;
    en_cnt = 0;
    k_done = 0;
    de = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, OP_NOP, 0, 1);
      v2 = 1'b0;
      if (en2) en_cnt++;
      if ((done2 || err2) && k_done == 0) begin
        k_done = k;
        de = {done2, err2};
      end
    end
    chk("dut2 en cycles", en_cnt, 3);
    chk("dut2 finish cycle", k_done, 6 + RB);
    chk("dut2 done/err", de, RB == 1 ? 2'b01 : 2'b10);
    for (int i = 0; i < 1500; i++) begin
      logic qf;
      qf = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), qf,
          $urandom_range(0, 3) == 0 ? qf : !qf);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
